// File: rtl/plat_scan_pkg.sv
// plat_scan_pkg: shared state encoding, owner codes and index width for the platform scanner
package plat_scan_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    localparam logic OWNER_PHYS = 1'b0;
    localparam logic OWNER_DRAW = 1'b1;
    localparam int DEF_IDX_WIDTH = 3;
endpackage

// File: rtl/plat_scan_if.sv
// plat_scan_if: requester handshake and platform beat stream of the scanner
interface plat_scan_if #(
    parameter int PHY_WIDTH       = 16,
    parameter int BLOCK_LEN_WIDTH = 4,
    parameter int IDX_WIDTH       = 3
);
    logic                       phys_req;
    logic                       draw_req;
    logic                       phys_gnt;
    logic                       draw_gnt;
    logic                       out_valid;
    logic [IDX_WIDTH-1:0]       out_idx;
    logic [PHY_WIDTH-1:0]       out_x;
    logic [PHY_WIDTH-1:0]       out_abs_y;
    logic [BLOCK_LEN_WIDTH-1:0] out_len;
    logic                       out_last;
    logic                       out_owner;
    logic                       scan_restart;
    logic                       busy;
    modport master (
        input  phys_req, draw_req,
        output phys_gnt, draw_gnt, out_valid, out_idx, out_x, out_abs_y, out_len,
               out_last, out_owner, scan_restart, busy
    );
    modport slave (
        output phys_req, draw_req,
        input  phys_gnt, draw_gnt, out_valid, out_idx, out_x, out_abs_y, out_len,
               out_last, out_owner, scan_restart, busy
    );
endinterface

// File: rtl/plat_scan_arb.sv
// plat_scan_arb: physics-priority arbiter that lets draw in after a bounded physics streak
module plat_scan_arb
    import plat_scan_pkg::*;
#(
    parameter int MAX_PHYS_STREAK = 2
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic phys_req,
    input  logic draw_req,
    input  logic arb_en,
    output logic gnt_owner,
    output logic gnt_valid
);
    localparam int SW = $clog2(MAX_PHYS_STREAK + 2);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_PHYS_STREAK);
    logic [SW-1:0] streak_q, streak_d;
    // pick the winner; streak only counts physics wins that kept draw waiting
    always_comb begin
        gnt_valid = arb_en && (phys_req || draw_req);
        gnt_owner = (draw_req && (!phys_req || streak_q == STREAK_MAX)) ? OWNER_DRAW : OWNER_PHYS;
        streak_d  = streak_q;
        if (gnt_valid)
            streak_d = (gnt_owner == OWNER_PHYS && draw_req)
                     ? ((streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1) : '0;
    end
    // streak register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) streak_q <= '0;
        else         streak_q <= streak_d;
    end
endmodule

// File: rtl/plat_scan_ctrl.sv
// plat_scan_ctrl: arbitrates physics/draw and streams one block's platforms, one per cycle
module plat_scan_ctrl
    import plat_scan_pkg::*;
#(
    parameter int PLATFORM_NUM_PER_BLOCK = 7,
    parameter int PHY_WIDTH              = 16,
    parameter int CAMERA_WIDTH           = 6,
    parameter int BLOCK_WIDTH            = 480,
    parameter int BLOCK_LEN_WIDTH        = 4,
    parameter int IDX_WIDTH              = DEF_IDX_WIDTH,
    parameter int MAX_PHYS_STREAK        = 2
) (
    input  logic                                              sys_clk,
    input  logic                                              sys_rst,
    input  logic [CAMERA_WIDTH-1:0]                           camera_y,
    input  logic                                              block_switch,
    input  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]       plat_relative_x,
    input  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]       plat_relative_y,
    input  logic [PLATFORM_NUM_PER_BLOCK*BLOCK_LEN_WIDTH-1:0] plat_len,
    plat_scan_if.master                                       bus
);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(PLATFORM_NUM_PER_BLOCK - 1);
    state_t                     state_q, state_d;
    logic [IDX_WIDTH-1:0]       idx_q, idx_d;
    logic                       owner_q, owner_d;
    logic                       restart_d, scan_d;
    logic                       arb_owner, arb_valid;
    logic [PHY_WIDTH-1:0]       x_d, abs_y_d, x_q, abs_y_q;
    logic [BLOCK_LEN_WIDTH-1:0] len_d, len_q;
    logic                       valid_q, last_q, out_owner_q, restart_q;
    logic                       phys_gnt_q, draw_gnt_q, busy_q;

    plat_scan_arb #(.MAX_PHYS_STREAK(MAX_PHYS_STREAK)) u_arb (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .phys_req  (bus.phys_req),
        .draw_req  (bus.draw_req),
        .arb_en    (state_q == IDLE),
        .gnt_owner (arb_owner),
        .gnt_valid (arb_valid)
    );

    // next state and next beat index; a block switch in SCAN rewinds to idx 0, even on the last beat
    always_comb begin
        state_d   = state_q;
        idx_d     = '0;
        owner_d   = owner_q;
        restart_d = 1'b0;
        unique case (state_q)
            IDLE: if (arb_valid) begin
                state_d = SCAN;
                owner_d = arb_owner;
            end
            SCAN: if (block_switch) restart_d = 1'b1;
                  else if (idx_q == LAST_IDX) state_d = DONE;
                  else idx_d = idx_q + 1'b1;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // beat payload for the next index, taken from this cycle's table
    always_comb begin
        scan_d  = state_d == SCAN;
        x_d     = plat_relative_x[idx_d*PHY_WIDTH +: PHY_WIDTH];
        len_d   = plat_len[idx_d*BLOCK_LEN_WIDTH +: BLOCK_LEN_WIDTH];
        abs_y_d = PHY_WIDTH'(camera_y) * PHY_WIDTH'(BLOCK_WIDTH)
                + plat_relative_y[idx_d*PHY_WIDTH +: PHY_WIDTH];
    end

    // state and registered outputs; everything outside a beat reads as zero
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            owner_q     <= OWNER_PHYS;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            out_owner_q <= 1'b0;
            restart_q   <= 1'b0;
            phys_gnt_q  <= 1'b0;
            draw_gnt_q  <= 1'b0;
            busy_q      <= 1'b0;
            x_q         <= '0;
            abs_y_q     <= '0;
            len_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            owner_q     <= owner_d;
            valid_q     <= scan_d;
            last_q      <= scan_d && idx_d == LAST_IDX;
            out_owner_q <= scan_d && owner_d == OWNER_DRAW;
            restart_q   <= restart_d;
            phys_gnt_q  <= scan_d && owner_d == OWNER_PHYS;
            draw_gnt_q  <= scan_d && owner_d == OWNER_DRAW;
            busy_q      <= state_d != IDLE;
            x_q         <= scan_d ? x_d : '0;
            abs_y_q     <= scan_d ? abs_y_d : '0;
            len_q       <= scan_d ? len_d : '0;
        end
    end

    assign bus.out_valid    = valid_q;
    assign bus.out_idx      = idx_q;
    assign bus.out_x        = x_q;
    assign bus.out_abs_y    = abs_y_q;
    assign bus.out_len      = len_q;
    assign bus.out_last     = last_q;
    assign bus.out_owner    = out_owner_q;
    assign bus.scan_restart = restart_q;
    assign bus.phys_gnt     = phys_gnt_q;
    assign bus.draw_gnt     = draw_gnt_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_plat_scan_ctrl.sv
// tb_plat_scan_ctrl: directed scenarios for the platform scan controller
module tb_plat_scan_ctrl;
    import plat_scan_pkg::*;
    localparam int N  = 7;
    localparam int PW = 16;
    localparam int CW = 6;
    localparam int LW = 4;
    localparam int IW = 3;

    logic            sys_clk = 1'b0;
    logic            sys_rst = 1'b1;
    logic            block_switch = 1'b0;
    logic [CW-1:0]   camera_y = '0;
    logic [N*PW-1:0] plat_relative_x = '0;
    logic [N*PW-1:0] plat_relative_y = '0;
    logic [N*LW-1:0] plat_len = '0;
    int n_chk = 0;
    int n_fail = 0;
    int m_cam, m_xb, m_yb, m_lb;

    plat_scan_if #(.PHY_WIDTH(PW), .BLOCK_LEN_WIDTH(LW), .IDX_WIDTH(IW)) bus ();

    plat_scan_ctrl #(
        .PLATFORM_NUM_PER_BLOCK(N), .PHY_WIDTH(PW), .CAMERA_WIDTH(CW), .BLOCK_WIDTH(480),
        .BLOCK_LEN_WIDTH(LW), .IDX_WIDTH(IW), .MAX_PHYS_STREAK(2)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .camera_y        (camera_y),
        .block_switch    (block_switch),
        .plat_relative_x (plat_relative_x),
        .plat_relative_y (plat_relative_y),
        .plat_len        (plat_len),
        .bus             (bus)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [45:0] got_beat();
        return {bus.out_valid, bus.out_idx, bus.out_x, bus.out_abs_y, bus.out_len, bus.out_last,
                bus.out_owner, bus.scan_restart, bus.phys_gnt, bus.draw_gnt, bus.busy};
    endfunction

    function automatic logic [45:0] exp_beat(int i, logic own, logic rs);
        logic [PW-1:0] ay;
        ay = PW'(m_cam * 480 + m_yb + 10 * i);
        return {1'b1, IW'(i), PW'(m_xb + 3 * i), ay, LW'(m_lb + i), i == N - 1, own, rs, !own, own, 1'b1};
    endfunction

    task automatic load_block(int cam, int xb, int yb, int lb);
        m_cam = cam; m_xb = xb; m_yb = yb; m_lb = lb;
        camera_y = CW'(cam);
        for (int i = 0; i < N; i++) begin
            plat_relative_x[i*PW +: PW] = PW'(xb + 3 * i);
            plat_relative_y[i*PW +: PW] = PW'(yb + 10 * i);
            plat_len[i*LW +: LW]        = LW'(lb + i);
        end
    endtask

    task automatic test_reset();
        bus.phys_req = 1'b0;
        bus.draw_req = 1'b0;
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        n_chk++;
        if (got_beat() !== '0) begin n_fail++; $display("FAIL reset got=%h exp=0", got_beat()); end
        sys_rst = 1'b0;
        @(negedge sys_clk);
        n_chk++;
        if (got_beat() !== '0) begin n_fail++; $display("FAIL idle_no_req got=%h exp=0", got_beat()); end
    endtask

    task automatic test_phys_only();
        load_block(2, 100, 35, 1);
        bus.phys_req = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(negedge sys_clk);
            if (i == 0) begin
                bus.phys_req = 1'b0;
                n_chk++;
                if (bus.out_abs_y !== 16'd995) begin n_fail++; $display("FAIL phys_abs_y0 got=%0d exp=995", bus.out_abs_y); end
            end
            n_chk++;
            if (got_beat() !== exp_beat(i, OWNER_PHYS, 1'b0)) begin
                n_fail++; $display("FAIL phys_beat%0d got=%h exp=%h", i, got_beat(), exp_beat(i, OWNER_PHYS, 1'b0));
            end
        end
        @(negedge sys_clk);
        n_chk++;
        if ({bus.out_valid, bus.phys_gnt, bus.draw_gnt, bus.busy, bus.out_last} !== 5'b00010) begin
            n_fail++; $display("FAIL phys_done got=%b exp=00010", {bus.out_valid, bus.phys_gnt, bus.draw_gnt, bus.busy, bus.out_last});
        end
        @(negedge sys_clk);
        n_chk++;
        if (got_beat() !== '0) begin n_fail++; $display("FAIL phys_idle got=%h exp=0", got_beat()); end
    endtask

    task automatic test_both_held();
        logic exp_own [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        bus.phys_req = 1'b1;
        bus.draw_req = 1'b1;
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < N; i++) begin
                @(negedge sys_clk);
                if (p == 5 && i == 0) begin bus.phys_req = 1'b0; bus.draw_req = 1'b0; end
                n_chk++;
                if (got_beat() !== exp_beat(i, exp_own[p], 1'b0)) begin
                    n_fail++; $display("FAIL both_pass%0d_beat%0d got=%h exp=%h", p, i, got_beat(), exp_beat(i, exp_own[p], 1'b0));
                end
            end
            @(negedge sys_clk);
            n_chk++;
            if ({bus.out_valid, bus.phys_gnt, bus.draw_gnt, bus.busy} !== 4'b0001) begin
                n_fail++; $display("FAIL both_done%0d got=%b exp=0001", p, {bus.out_valid, bus.phys_gnt, bus.draw_gnt, bus.busy});
            end
            @(negedge sys_clk);
            n_chk++;
            if ({bus.out_valid, bus.busy} !== 2'b00) begin
                n_fail++; $display("FAIL both_idle%0d got=%b exp=00", p, {bus.out_valid, bus.busy});
            end
        end
    endtask

    task automatic test_switch_mid();
        int beats = 0;
        load_block(2, 100, 35, 1);
        bus.phys_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            bus.phys_req = 1'b0;
            beats += int'(bus.out_valid);
            n_chk++;
            if (got_beat() !== exp_beat(i, OWNER_PHYS, 1'b0)) begin
                n_fail++; $display("FAIL mid_pre%0d got=%h exp=%h", i, got_beat(), exp_beat(i, OWNER_PHYS, 1'b0));
            end
        end
        load_block(5, 200, 50, 3);
        block_switch = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(negedge sys_clk);
            block_switch = 1'b0;
            beats += int'(bus.out_valid);
            n_chk++;
            if (got_beat() !== exp_beat(i, OWNER_PHYS, i == 0)) begin
                n_fail++; $display("FAIL mid_post%0d got=%h exp=%h", i, got_beat(), exp_beat(i, OWNER_PHYS, i == 0));
            end
        end
        @(negedge sys_clk);
        beats += int'(bus.out_valid);
        n_chk++;
        if (beats !== 11 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_total beats=%0d busy=%b exp beats=11 busy=1", beats, bus.busy);
        end
        @(negedge sys_clk);
    endtask

    task automatic test_switch_last();
        bus.phys_req = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(negedge sys_clk);
            bus.phys_req = 1'b0;
            n_chk++;
            if (got_beat() !== exp_beat(i, OWNER_PHYS, 1'b0)) begin
                n_fail++; $display("FAIL last_pre%0d got=%h exp=%h", i, got_beat(), exp_beat(i, OWNER_PHYS, 1'b0));
            end
        end
        load_block(7, 300, 20, 5);
        block_switch = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(negedge sys_clk);
            block_switch = 1'b0;
            n_chk++;
            if (got_beat() !== exp_beat(i, OWNER_PHYS, i == 0)) begin
                n_fail++; $display("FAIL last_post%0d got=%h exp=%h", i, got_beat(), exp_beat(i, OWNER_PHYS, i == 0));
            end
        end
        @(negedge sys_clk);
        n_chk++;
        if ({bus.out_valid, bus.busy} !== 2'b01) begin
            n_fail++; $display("FAIL last_done got=%b exp=01", {bus.out_valid, bus.busy});
        end
        @(negedge sys_clk);
    endtask

    task automatic test_reset_mid();
        int w = 0;
        bus.phys_req = 1'b1;
        bus.draw_req = 1'b1;
        @(negedge sys_clk);
        n_chk++;
        if (got_beat() !== exp_beat(0, OWNER_PHYS, 1'b0)) begin
            n_fail++; $display("FAIL rstmid_pass1 got=%h exp=%h", got_beat(), exp_beat(0, OWNER_PHYS, 1'b0));
        end
        repeat (N + 1) @(negedge sys_clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            n_chk++;
            if (got_beat() !== exp_beat(i, OWNER_PHYS, 1'b0)) begin
                n_fail++; $display("FAIL rstmid_pass2_%0d got=%h exp=%h", i, got_beat(), exp_beat(i, OWNER_PHYS, 1'b0));
            end
        end
        sys_rst = 1'b1;
        @(negedge sys_clk);
        n_chk++;
        if (got_beat() !== '0) begin n_fail++; $display("FAIL rstmid_zero got=%h exp=0", got_beat()); end
        sys_rst = 1'b0;
        @(negedge sys_clk);
        bus.phys_req = 1'b0;
        bus.draw_req = 1'b0;
        n_chk++;
        if (got_beat() !== exp_beat(0, OWNER_PHYS, 1'b0)) begin
            n_fail++; $display("FAIL rstmid_streak got=%h exp=%h", got_beat(), exp_beat(0, OWNER_PHYS, 1'b0));
        end
        while (bus.busy && w < 20) begin @(negedge sys_clk); w++; end
        n_chk++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_drain busy=%b exp=0", bus.busy); end
    endtask

    task automatic test_max();
        int w = 0;
        load_block(63, 0, 479, 0);
        bus.phys_req = 1'b1;
        @(negedge sys_clk);
        bus.phys_req = 1'b0;
        n_chk++;
        if (bus.out_abs_y !== 16'd30719) begin n_fail++; $display("FAIL max_abs_y got=%0d exp=30719", bus.out_abs_y); end
        n_chk++;
        if (got_beat() !== exp_beat(0, OWNER_PHYS, 1'b0)) begin
            n_fail++; $display("FAIL max_beat got=%h exp=%h", got_beat(), exp_beat(0, OWNER_PHYS, 1'b0));
        end
        while (bus.busy && w < 20) begin @(negedge sys_clk); w++; end
        n_chk++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL max_drain busy=%b exp=0", bus.busy); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_phys_only();
        test_both_held();
        test_switch_mid();
        test_switch_last();
        test_reset_mid();
        test_max();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
